// File: rtl/jam_pkg.sv
// Shared JAM definitions: table geometry, cost/sum widths and the responder state encoding.
// The search engine imports the same saturation ceiling so both sides agree on the cost range.
package jam_pkg;

   localparam int JAM_N        = 8;
   localparam int JAM_IDX_W    = $clog2(JAM_N);
   localparam int JAM_ADDR_W   = 2 * JAM_IDX_W;
   localparam int JAM_COST_W   = 7;
   localparam int JAM_SUM_W    = 10;
   localparam int JAM_MAX_COST = 100;

   typedef logic [JAM_COST_W-1:0] cost_t;
   typedef logic [JAM_SUM_W-1:0]  sum_t;
   typedef logic [JAM_ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_READY = 2'd2
   } state_e;

   // Flat table address, row-major: worker selects the row, job the column.
   function automatic addr_t jam_addr(input logic [JAM_IDX_W-1:0] w,
                                      input logic [JAM_IDX_W-1:0] j);
      return {w, j};
   endfunction

endpackage

// File: rtl/jam_cost_mem.sv
// Cost table storage: one synchronous write port and two combinational read ports,
// one serving initiator queries and one feeding the row-minimum scan.
module jam_cost_mem #(
   parameter int COST_W = 7,
   parameter int ADDR_W = 6
) (
   input  logic              CLK,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [COST_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0] q_addr_i,
   output logic [COST_W-1:0] q_data_o,
   input  logic [ADDR_W-1:0] s_addr_i,
   output logic [COST_W-1:0] s_data_o
);

   logic [COST_W-1:0] mem_q [2**ADDR_W];

   // Contents are deliberately not reset; validity is tracked by the responder FSM.
   always_ff @(posedge CLK) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign q_data_o = mem_q[q_addr_i];
   assign s_data_o = mem_q[s_addr_i];

endmodule

// File: rtl/jam_cost_responder.sv
// JAM cost-query responder: loads the 8x8 cost table from a ready/valid stream, then scans it
// once to produce the sum of row minima, after which (W,J) queries are answered combinationally.
module jam_cost_responder
   import jam_pkg::*;
#(
   parameter int MAX_COST = JAM_MAX_COST,
   parameter int COST_W   = JAM_COST_W,
   parameter int SUM_W    = JAM_SUM_W
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [JAM_IDX_W-1:0] W,
   input  logic [JAM_IDX_W-1:0] J,
   output logic [COST_W-1:0]    Cost,
   input  logic                 ld_valid,
   input  logic [COST_W-1:0]    ld_data,
   output logic                 ld_ready,
   input  logic                 ld_reload,
   output logic                 Ready,
   output logic [SUM_W-1:0]     LowerBound,
   output logic                 Sat
);

   localparam logic [COST_W-1:0] MAX_C = COST_W'(MAX_COST);

   state_e                  state_q,     state_d;
   logic [JAM_ADDR_W-1:0]   ld_addr_q,   ld_addr_d;
   logic [JAM_ADDR_W-1:0]   scan_addr_q, scan_addr_d;
   logic [COST_W-1:0]       row_min_q,   row_min_d;
   logic [SUM_W-1:0]        lb_q,        lb_d;
   logic                    sat_q,       sat_d;

   logic                    wr_en;
   logic [COST_W-1:0]       wr_data;
   logic [COST_W-1:0]       q_data;
   logic [COST_W-1:0]       scan_data;
   logic [COST_W-1:0]       scan_min;
   logic                    over_max;

   jam_cost_mem #(
      .COST_W (COST_W),
      .ADDR_W (JAM_ADDR_W)
   ) u_mem (
      .CLK       (CLK),
      .wr_en_i   (wr_en),
      .wr_addr_i (ld_addr_q),
      .wr_data_i (wr_data),
      .q_addr_i  (jam_addr(W, J)),
      .q_data_o  (q_data),
      .s_addr_i  (scan_addr_q),
      .s_data_o  (scan_data)
   );

   assign over_max = (ld_data > MAX_C);
   assign wr_data  = over_max ? MAX_C : ld_data;
   assign scan_min = (scan_data < row_min_q) ? scan_data : row_min_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_LOAD;
         ld_addr_q   <= '0;
         scan_addr_q <= '0;
         row_min_q   <= '0;
         lb_q        <= '0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_addr_q   <= ld_addr_d;
         scan_addr_q <= scan_addr_d;
         row_min_q   <= row_min_d;
         lb_q        <= lb_d;
         sat_q       <= sat_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ld_addr_d   = ld_addr_q;
      scan_addr_d = scan_addr_q;
      row_min_d   = row_min_q;
      lb_d        = lb_q;
      sat_d       = sat_q;
      wr_en       = 1'b0;

      case (state_q)
         ST_LOAD: begin
            if (ld_valid) begin
               wr_en     = 1'b1;
               ld_addr_d = ld_addr_q + 1'b1;
               if (over_max) begin
                  sat_d = 1'b1;
               end
               if (ld_addr_q == '1) begin
                  state_d     = ST_SCAN;
                  scan_addr_d = '0;
               end
            end
         end

         ST_SCAN: begin
            scan_addr_d = scan_addr_q + 1'b1;
            // Column 0 seeds the row minimum; the last column folds it into the bound.
            if (scan_addr_q[JAM_IDX_W-1:0] == '0) begin
               row_min_d = scan_data;
            end else if (scan_addr_q[JAM_IDX_W-1:0] != '1) begin
               row_min_d = scan_min;
            end else begin
               lb_d = lb_q + {{(SUM_W-COST_W){1'b0}}, scan_min};
            end
            if (scan_addr_q == '1) begin
               state_d = ST_READY;
            end
         end

         ST_READY: begin
            if (ld_reload) begin
               state_d   = ST_LOAD;
               ld_addr_d = '0;
               lb_d      = '0;
               sat_d     = 1'b0;
            end
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   assign ld_ready   = (state_q == ST_LOAD);
   assign Ready      = (state_q == ST_READY);
   assign LowerBound = lb_q;
   assign Sat        = sat_q;
   assign Cost       = (state_q == ST_READY) ? q_data : '0;

endmodule

// File: tb/tb_jam_cost_responder.sv
// Self-checking bench for jam_cost_responder: scenario tasks with a reference table model
// and a queue of expected query results.
module tb_jam_cost_responder;

   logic       CLK = 1'b0;
   logic       RST;
   logic [2:0] W, J;
   logic [6:0] Cost;
   logic       ld_valid;
   logic [6:0] ld_data;
   logic       ld_ready;
   logic       ld_reload;
   logic       Ready;
   logic [9:0] LowerBound;
   logic       Sat;

   jam_cost_responder dut (
      .CLK        (CLK),
      .RST        (RST),
      .W          (W),
      .J          (J),
      .Cost       (Cost),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .ld_reload  (ld_reload),
      .Ready      (Ready),
      .LowerBound (LowerBound),
      .Sat        (Sat)
   );

   always #5 CLK = ~CLK;

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [6:0] stim    [64];
   logic [6:0] exp_tab [64];
   logic       exp_sat;
   int         exp_lb;
   logic [6:0] cost_q [$];

   task automatic build_model();
      int m;
      exp_sat = 1'b0;
      exp_lb  = 0;
      for (int i = 0; i < 64; i++) begin
         exp_tab[i] = (stim[i] > 7'd100) ? 7'd100 : stim[i];
         if (stim[i] > 7'd100) exp_sat = 1'b1;
      end
      for (int w = 0; w < 8; w++) begin
         m = 1000;
         for (int j = 0; j < 8; j++)
            if (int'(exp_tab[w*8+j]) < m) m = int'(exp_tab[w*8+j]);
         exp_lb += m;
      end
   endtask

   // Drives the 64 beats of stim; returns at the negedge where the final beat is presented.
   task automatic load_stream(input bit toggle);
      build_model();
      for (int i = 0; i < 64; i++) begin
         if (toggle && i > 0) begin
            @(negedge CLK);
            ld_valid = 1'b0;
            ld_data  = 7'h7f;
         end
         @(negedge CLK);
         ld_valid = 1'b1;
         ld_data  = stim[i];
      end
   endtask

   // Counts edges after the final accepted beat until Ready; -1 when the budget expires.
   task automatic wait_ready(input int reload_at, output int cycles, output logic ldr_after);
      cycles    = -1;
      ldr_after = 1'bx;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK);
         if (k == 0) ldr_after = ld_ready;
         ld_valid  = (reload_at >= 0);
         ld_data   = 7'h7f;
         ld_reload = (k == reload_at);
         if (Ready) begin
            cycles = k;
            break;
         end
      end
      ld_valid  = 1'b0;
      ld_reload = 1'b0;
   endtask

   task automatic do_reload();
      @(negedge CLK);
      ld_reload = 1'b1;
      @(negedge CLK);
      ld_reload = 1'b0;
   endtask

   task automatic issue_query(input int w, input int j);
      @(negedge CLK);
      W = 3'(w);
      J = 3'(j);
      cost_q.push_back(exp_tab[w*8+j]);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] e;
      RST = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_reload = 1'b0; W = 3'd5; J = 3'd3;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      tests_run++;
      if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
      tests_run++;
      if (Ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b want 0", Ready); end
      tests_run++;
      if (LowerBound !== 10'd0) begin tests_failed++; $display("FAIL reset_lb got %0d want 0", LowerBound); end
      tests_run++;
      if (Sat !== 1'b0) begin tests_failed++; $display("FAIL reset_sat got %b want 0", Sat); end
      e = 7'd0;
      tests_run++;
      if (Cost !== e) begin tests_failed++; $display("FAIL reset_cost got %0d want %0d", Cost, e); end
      $display("[TB] reset: ld_ready=%b Ready=%b LB=%0d Sat=%b Cost=%0d", ld_ready, Ready, LowerBound, Sat, Cost);
   endtask

   task automatic test_ramp();
      int c; logic l; logic [6:0] e;
      for (int i = 0; i < 64; i++) stim[i] = 7'(i);
      load_stream(1'b0);
      tests_run++;
      if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL ramp_ld_ready_before got %b want 1", ld_ready); end
      wait_ready(-1, c, l);
      tests_run++;
      if (l !== 1'b0) begin tests_failed++; $display("FAIL ramp_ld_ready_after got %b want 0", l); end
      tests_run++;
      if (c != 64) begin tests_failed++; $display("FAIL ramp_latency got %0d want 64", c); end
      tests_run++;
      if (LowerBound !== 10'd224) begin tests_failed++; $display("FAIL ramp_lb got %0d want 224", LowerBound); end
      tests_run++;
      if (Sat !== 1'b0) begin tests_failed++; $display("FAIL ramp_sat got %b want 0", Sat); end
      issue_query(5, 3);
      e = cost_q.pop_front();
      tests_run++;
      if (Cost !== e || Cost !== 7'd43) begin tests_failed++; $display("FAIL ramp_cost_5_3 got %0d want 43", Cost); end
      for (int n = 0; n < 6; n++) begin
         issue_query($urandom_range(7), $urandom_range(7));
         e = cost_q.pop_front();
         tests_run++;
         if (Cost !== e) begin tests_failed++; $display("FAIL ramp_cost W=%0d J=%0d got %0d want %0d", W, J, Cost, e); end
      end
      $display("[TB] ramp: latency=%0d LB=%0d Sat=%b", c, LowerBound, Sat);
   endtask

   task automatic test_toggle();
      int c; logic l; logic [6:0] e;
      do_reload();
      for (int i = 0; i < 64; i++) stim[i] = 7'((i >> 3) + (i & 7));
      load_stream(1'b1);
      wait_ready(-1, c, l);
      tests_run++;
      if (c != 64) begin tests_failed++; $display("FAIL toggle_latency got %0d want 64", c); end
      tests_run++;
      if (LowerBound !== 10'd28) begin tests_failed++; $display("FAIL toggle_lb got %0d want 28", LowerBound); end
      tests_run++;
      if (Sat !== 1'b0) begin tests_failed++; $display("FAIL toggle_sat got %b want 0", Sat); end
      for (int a = 0; a < 64; a++) begin
         issue_query(a >> 3, a & 7);
         e = cost_q.pop_front();
         tests_run++;
         if (Cost !== e) begin tests_failed++; $display("FAIL toggle_cost W=%0d J=%0d got %0d want %0d", W, J, Cost, e); end
      end
      $display("[TB] toggle: latency=%0d LB=%0d Sat=%b", c, LowerBound, Sat);
   endtask

   task automatic test_saturation();
      int c; logic l; logic [6:0] e;
      do_reload();
      for (int i = 0; i < 64; i++) stim[i] = 7'd100;
      stim[2*8+4] = 7'd127;
      load_stream(1'b0);
      wait_ready(-1, c, l);
      tests_run++;
      if (Sat !== 1'b1) begin tests_failed++; $display("FAIL sat_flag got %b want 1", Sat); end
      tests_run++;
      if (LowerBound !== 10'd800) begin tests_failed++; $display("FAIL sat_lb got %0d want 800", LowerBound); end
      issue_query(2, 4);
      e = cost_q.pop_front();
      tests_run++;
      if (Cost !== e || Cost !== 7'd100) begin tests_failed++; $display("FAIL sat_cost_2_4 got %0d want 100", Cost); end
      $display("[TB] saturation: latency=%0d LB=%0d Sat=%b", c, LowerBound, Sat);
   endtask

   task automatic test_reload_with_valid();
      int c; logic l; logic [6:0] e;
      @(negedge CLK);
      ld_reload = 1'b1; ld_valid = 1'b1; ld_data = 7'd5;
      @(negedge CLK);
      ld_reload = 1'b0; ld_valid = 1'b0;
      tests_run++;
      if (Ready !== 1'b0 || ld_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reload_state got Ready=%b ld_ready=%b want 0/1", Ready, ld_ready);
      end
      tests_run++;
      if (LowerBound !== 10'd0 || Sat !== 1'b0) begin
         tests_failed++; $display("FAIL reload_clear got LB=%0d Sat=%b want 0/0", LowerBound, Sat);
      end
      for (int i = 0; i < 64; i++) stim[i] = 7'd1;
      load_stream(1'b0);
      wait_ready(-1, c, l);
      tests_run++;
      if (c != 64) begin tests_failed++; $display("FAIL reload_latency got %0d want 64", c); end
      tests_run++;
      if (LowerBound !== 10'd8) begin tests_failed++; $display("FAIL reload_lb got %0d want 8", LowerBound); end
      issue_query(0, 0);
      e = cost_q.pop_front();
      tests_run++;
      if (Cost !== e) begin tests_failed++; $display("FAIL reload_cost_0_0 got %0d want %0d", Cost, e); end
      $display("[TB] reload_with_valid: latency=%0d LB=%0d Cost00=%0d", c, LowerBound, Cost);
   endtask

   task automatic test_reset_mid_load();
      int c; logic l; logic [6:0] e;
      do_reload();
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         ld_valid = 1'b1; ld_data = 7'd127;
      end
      @(negedge CLK);
      ld_valid = 1'b0; RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      tests_run++;
      if (Ready !== 1'b0 || ld_ready !== 1'b1) begin
         tests_failed++; $display("FAIL midrst_state got Ready=%b ld_ready=%b want 0/1", Ready, ld_ready);
      end
      tests_run++;
      if (Sat !== 1'b0 || LowerBound !== 10'd0) begin
         tests_failed++; $display("FAIL midrst_clear got Sat=%b LB=%0d want 0/0", Sat, LowerBound);
      end
      for (int i = 0; i < 64; i++) stim[i] = 7'($urandom_range(127));
      load_stream(1'b0);
      wait_ready(-1, c, l);
      tests_run++;
      if (c != 64) begin tests_failed++; $display("FAIL midrst_latency got %0d want 64", c); end
      tests_run++;
      if (LowerBound !== 10'(exp_lb)) begin tests_failed++; $display("FAIL midrst_lb got %0d want %0d", LowerBound, exp_lb); end
      tests_run++;
      if (Sat !== exp_sat) begin tests_failed++; $display("FAIL midrst_sat got %b want %b", Sat, exp_sat); end
      for (int a = 0; a < 64; a += 5) begin
         issue_query(a >> 3, a & 7);
         e = cost_q.pop_front();
         tests_run++;
         if (Cost !== e) begin tests_failed++; $display("FAIL midrst_cost W=%0d J=%0d got %0d want %0d", W, J, Cost, e); end
      end
      $display("[TB] reset_mid_load: latency=%0d LB=%0d Sat=%b", c, LowerBound, Sat);
   endtask

   task automatic test_reload_in_scan();
      int c; logic l;
      do_reload();
      for (int i = 0; i < 64; i++) stim[i] = 7'($urandom_range(20, 90));
      load_stream(1'b0);
      wait_ready(10, c, l);
      tests_run++;
      if (c != 64) begin tests_failed++; $display("FAIL scanrl_latency got %0d want 64", c); end
      tests_run++;
      if (LowerBound !== 10'(exp_lb)) begin tests_failed++; $display("FAIL scanrl_lb got %0d want %0d", LowerBound, exp_lb); end
      @(negedge CLK);
      tests_run++;
      if (Ready !== 1'b1) begin tests_failed++; $display("FAIL scanrl_ready_hold got %b want 1", Ready); end
      $display("[TB] reload_in_scan: latency=%0d LB=%0d", c, LowerBound);
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_toggle();
      test_saturation();
      test_reload_with_valid();
      test_reset_mid_load();
      test_reload_in_scan();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/jam_cost_responder.md
Name: jam_cost_responder

Overview:
Responder side of the JAM worker/job cost-query interface: holds the 8x8 cost table and answers (W,J) queries with Cost in the same cycle.
The table is filled through a ready/valid load stream.
After loading, an internal scan computes the sum of row minima. This is a lower bound on any assignment cost and is reported to the initiator side for early-termination checks.
Sits between the pattern/loader source and the JAM search engine.

Parameters:
MAX_COST, 100, saturation ceiling applied to every loaded cost
COST_W, 7, width of one cost entry
SUM_W, 10, width of LowerBound (8 x 100 = 800 < 1024)

Ports:
CLK  in  1  clock
RST  in  1  reset
W  in  3  worker index of query
J  in  3  job index of query
Cost  out  COST_W  cost of (W,J); combinational read
ld_valid  in  1  load beat valid
ld_data  in  COST_W  load beat data, row-major order (W=0,J=0..7, then W=1, ...)
ld_ready  out  1  table accepts a beat
ld_reload  in  1  single-cycle request to reload the table
Ready  out  1  table loaded and scan complete; queries valid
LowerBound  out  SUM_W  sum over W of min_J cost[W][J]; valid when Ready=1
Sat  out  1  sticky: at least one loaded value exceeded MAX_COST

Behaviour:
- Reset RST, synchronous, active-high; clock CLK.
- Reset state: LOAD, ld_ready=1, Ready=0, LowerBound=0, Sat=0, load address=0, scan address=0. Memory contents are not reset.
- Storage: 64 x COST_W registers, address = {W,J}.
- States: LOAD -> SCAN -> READY; READY -> LOAD on ld_reload.
- LOAD:
  - ld_ready=1.
  - Beat accepted when ld_valid&ld_ready: mem[addr] <= min(ld_data, MAX_COST). If ld_data > MAX_COST, Sat <= 1. addr increments.
  - ld_valid low: no write, addr holds (back-pressure-free stall).
  - Acceptance at addr 63 -> SCAN with scan addr=0. ld_ready=0 from the next cycle.
- SCAN:
  - ld_ready=0; beats are ignored.
  - One entry per cycle, in address order.
  - J=0: row_min <= entry.
  - J=1..6: row_min <= min(row_min, entry).
  - J=7: LowerBound <= LowerBound + min(row_min, entry).
  - After entry 63 is processed -> READY.
  - Ready rises exactly 64 cycles after the cycle that accepted the last beat.
- READY:
  - Ready=1; Cost = mem[{W,J}] combinationally, so the initiator may register W/J and sample Cost on the next edge.
  - Outside READY, Cost=0.
- ld_reload:
  - Honoured only in READY. Next cycle: LOAD, Ready=0, ld_ready=1, addr=0, LowerBound=0, Sat=0.
  - Ignored in LOAD and SCAN.
  - ld_reload together with ld_valid in READY: the beat is not accepted (ld_ready is still 0 that cycle).
- Arithmetic:
  - Comparisons are unsigned COST_W.
  - LowerBound is a SUM_W-bit accumulation; overflow is impossible with MAX_COST=100.
- Reset mid-LOAD or mid-SCAN: returns to the reset state; the partial table is discarded logically (must be fully reloaded).
- W/J change while not READY: no effect on state.

Decomposition:
- Shared package jam_pkg:
  - JAM_N=8 and COST_W/SUM_W defaults.
  - cost_t and sum_t typedefs.
  - State enum {LOAD, SCAN, READY}.
  - MAX_COST constant (shared with the JAM search engine).
- One natural sub-module: jam_cost_mem (64xCOST_W register file, one write port, two async read ports: query and scan).
- FSM, clamp and scan accumulator stay in the top.

Test Plan:
- Load cost[w][j]=w*8+j, 64 consecutive beats -> ld_ready falls after beat 64; Ready=1 exactly 64 cycles later; LowerBound=0+8+...+56=224; query W=5,J=3 -> Cost=43.
- Load cost=w+j with ld_valid toggling every other cycle -> all 64 beats stored correctly; LowerBound=28; Sat=0.
- Load all 100 except cost[2][4]=127 -> Cost(2,4)=100; Sat=1; LowerBound=800.
- In READY pulse ld_reload with ld_valid=1 -> that beat not written; Ready=0 next cycle; reload all 1s -> LowerBound=8.
- Assert RST after 30 beats -> Ready=0, ld_ready=1, addr=0; full 64-beat reload gives correct table and LowerBound.
- ld_reload pulsed during SCAN -> ignored; Ready still rises at cycle 64 with correct LowerBound.
